id_ex_stage_reg: RTL and testbench

//  Pipeline register between decode and execute: the upstream end of the execute operand/control interface.

---
 rtl/id_ex_stage_reg.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, writeback bypass,
// flush/freeze handling and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DW    = 16,
  parameter int RW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alu_b_imm,
  input  logic [DW-1:0]    id_vX,
  input  logic [DW-1:0]    id_vY,
  input  logic [DW-1:0]    id_imm16,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             wb_we,
  input  logic [RW-1:0]    wb_rd,
  input  logic [DW-1:0]    wb_data,
  input  logic             flush,
  input  logic             freeze,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic             ex_alu_b_imm,
  output logic [DW-1:0]    ex_vX,
  output logic [DW-1:0]    ex_vY,
  output logic [DW-1:0]    ex_imm16,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_q, valid_d;
  logic [3:0]       op_q, op_d;
  logic             bimm_q, bimm_d;
  logic [DW-1:0]    vx_q, vx_d;
  logic [DW-1:0]    vy_q, vy_d;
  logic [DW-1:0]    imm_q, imm_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic             rw_q, rw_d;
  logic             mr_q, mr_d;
  logic             mw_q, mw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             rs_hit, rt_hit;

  assign rs_hit = id_uses_rs & (id_rs == rd_q);
  assign rt_hit = id_uses_rt & (id_rt == rd_q);
  assign hazard = id_valid & valid_q & mr_q
                & (rs_hit | rt_hit);

  assign stall_id = (hazard | freeze) & ~rst & ~flush;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    bimm_d  = bimm_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end else if (freeze) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end else begin
      valid_d = id_valid;
      op_d    = id_alu_op;
      bimm_d  = id_alu_b_imm;
      imm_d   = id_imm16;
      rd_d    = id_rd;
      rw_d    = id_valid & id_reg_write;
      mr_d    = id_valid & id_mem_read;
      mw_d    = id_valid & id_mem_write;
      // r0 is an ordinary register here, so no zero-id exclusion
      vx_d = (wb_we && wb_rd == id_rs) ? wb_data : id_vX;
      vy_d = (wb_we && wb_rd == id_rt) ? wb_data : id_vY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      bimm_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      bimm_q  <= bimm_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alu_op    = op_q;
  assign ex_alu_b_imm = bimm_q;
  assign ex_vX        = vx_q;
  assign ex_vY        = vy_q;
  assign ex_imm16     = imm_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = rw_q;
  assign ex_mem_read  = mr_q;
  assign ex_mem_write = mw_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; a second CNT_W=2
// instance shares stimulus to exercise counter saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_alu_b_imm;
  logic [3:0]  id_alu_op;
  logic [15:0] id_vX, id_vY, id_imm16;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush, freeze;

  logic        stall_id, ex_valid, ex_alu_b_imm;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_vX, ex_vY, ex_imm16;
  logic [2:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [15:0] bubble_cnt;

  logic        s_stall, s_valid, s_bimm;
  logic [3:0]  s_op;
  logic [15:0] s_vx, s_vy, s_imm;
  logic [2:0]  s_rd;
  logic        s_rw, s_mr, s_mw;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg u_dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_alu_b_imm(id_alu_b_imm),
    .id_vX(id_vX), .id_vY(id_vY), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .freeze(freeze),
    .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_alu_b_imm(ex_alu_b_imm),
    .ex_vX(ex_vX), .ex_vY(ex_vY), .ex_imm16(ex_imm16),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_alu_b_imm(id_alu_b_imm),
    .id_vX(id_vX), .id_vY(id_vY), .id_imm16(id_imm16),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .freeze(freeze),
    .stall_id(s_stall), .ex_valid(s_valid),
    .ex_alu_op(s_op), .ex_alu_b_imm(s_bimm),
    .ex_vX(s_vx), .ex_vY(s_vy), .ex_imm16(s_imm),
    .ex_rd(s_rd), .ex_reg_write(s_rw),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw),
    .bubble_cnt(s_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs,
                       input logic [2:0] rt, input logic urs,
                       input logic urt, input logic [2:0] rd,
                       input logic rw, input logic mr,
                       input logic [15:0] vx,
                       input logic [15:0] vy);
    id_valid     = v;
    id_alu_op    = 4'h1;
    id_alu_b_imm = 1'b0;
    id_imm16     = vx ^ vy;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_mem_write = 1'b0;
    vX_set(vx, vy);
  endtask

  task automatic vX_set(input logic [15:0] vx,
                        input logic [15:0] vy);
    id_vX = vx;
    id_vY = vy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b1;
    wb_we = 1'b1; wb_rd = 3'd0; wb_data = 16'hDEAD;
    drive(1'b1, 3'($urandom), 3'($urandom), 1'b1, 1'b1,
          3'($urandom), 1'b1, 1'b1,
          16'($urandom), 16'($urandom));
    #1;
    check("rst_stall", stall_id, 0);
    tick();
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_vx", ex_vX, 0);
    check("rst_vy", ex_vY, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_stall2", stall_id, 0);

    rst = 1'b0; freeze = 1'b0; wb_we = 1'b0;
    drive(1, 1, 2, 1, 1, 3, 1, 0, 16'h0005, 16'h0007);
    #1;
    check("add_stall", stall_id, 0);
    tick();
    check("add_valid", ex_valid, 1);
    check("add_vx", ex_vX, 16'h0005);
    check("add_vy", ex_vY, 16'h0007);
    check("add_rd", ex_rd, 3);
    check("add_rw", ex_reg_write, 1);
    check("add_op", ex_alu_op, 4'h1);

    drive(1, 1, 0, 1, 0, 4, 1, 1, 16'h0010, 16'h0000);
    #1;
    check("ld_nostall", stall_id, 0);
    tick();
    check("ld_mr", ex_mem_read, 1);
    drive(1, 4, 2, 1, 1, 5, 1, 0, 16'h0020, 16'h0030);
    #1;
    check("lu_stall", stall_id, 1);
    tick();
    check("lu_bub_valid", ex_valid, 0);
    check("lu_bub_ctl", {ex_reg_write, ex_mem_read}, 0);
    check("lu_cnt", bubble_cnt, 1);
    check("lu_unstall", stall_id, 0);
    tick();
    check("lu_valid", ex_valid, 1);
    check("lu_rd", ex_rd, 5);
    check("lu_vx", ex_vX, 16'h0020);
    check("lu_cnt2", bubble_cnt, 1);

    drive(1, 1, 0, 1, 0, 6, 1, 1, 16'h0001, 16'h0000);
    tick();
    drive(1, 6, 6, 0, 0, 7, 1, 0, 16'h0002, 16'h0003);
    #1;
    check("nouse_stall", stall_id, 0);
    tick();
    check("nouse_rd", ex_rd, 7);
    check("nouse_cnt", bubble_cnt, 1);

    drive(1, 2, 3, 1, 1, 1, 1, 0, 16'h1111, 16'h2222);
    wb_we = 1'b1; wb_rd = 3'd2; wb_data = 16'hBEEF;
    tick();
    check("byp_vx", ex_vX, 16'hBEEF);
    check("byp_vy", ex_vY, 16'h2222);
    wb_rd = 3'd5;
    tick();
    check("nobyp_vx", ex_vX, 16'h1111);
    wb_rd = 3'd3;
    tick();
    check("byp_vy2", ex_vY, 16'hBEEF);
    drive(1, 0, 3, 1, 1, 2, 1, 0, 16'h4444, 16'h5555);
    wb_rd = 3'd0; wb_data = 16'hCAFE;
    tick();
    check("byp_r0", ex_vX, 16'hCAFE);
    check("byp_r0_vy", ex_vY, 16'h5555);
    wb_we = 1'b0;

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'(i), 3'(i + 1), 1, 1, 3'(i + 4), 0, 1,
            16'(16'h9000 + i), 16'(16'h8000 + i));
      #1;
      check("frz_stall", stall_id, 1);
      tick();
      check("frz_vx", ex_vX, 16'hCAFE);
      check("frz_rd", ex_rd, 2);
      check("frz_valid", ex_valid, 1);
    end
    flush = 1'b1;
    #1;
    check("fl_stall", stall_id, 0);
    tick();
    check("fl_valid", ex_valid, 0);
    check("fl_ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    flush = 1'b0; freeze = 1'b0;

    for (int n = 1; n <= 5; n++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 1, 16'h0, 16'h0);
      tick();
      drive(1, 2, 1, 0, 1, 3, 1, 0, 16'h0, 16'h0);
      tick();
      tick();
      check("sat_main", bubble_cnt, 1 + n);
      check("sat_small", s_cnt, (1 + n > 3) ? 3 : 1 + n);
    end

    drive(1, 0, 0, 0, 0, 2, 1, 1, 16'h0, 16'h0);
    tick();
    drive(1, 2, 0, 1, 0, 3, 1, 0, 16'h0, 16'h0);
    #1;
    check("mid_stall", stall_id, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall_id, 0);
    tick();
    check("mid_valid", ex_valid, 0);
    check("mid_cnt", bubble_cnt, 0);
    rst = 1'b0;
    #1;
    check("mid_after", stall_id, 0);
    tick();
    check("mid_load", ex_valid, 1);
    check("mid_rd", ex_rd, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
